ddr3_line_prefetch: RTL

//  Sits directly upstream of the DDR3 line reader: issues one 1024-bit line read at a time
//  (rd_valid/rd_addr), captures the returned line (ddr3_data_valid/ddr3_rd_data) into a

---
 rtl/ddr3_line_prefetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/ddr3_line_prefetch.sv
// Line prefetcher between the DDR3 line reader and the VGA pixel path: fetches
// one 1024-bit line at a time into a small line buffer and streams 32-bit words.
module ddr3_line_prefetch #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FRAME_BLOCKS = 1024
) (
  input  logic          ddr3_clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          frame_start,
  output logic          rd_valid,
  output logic [9:0]    rd_addr,
  input  logic          ddr3_data_valid,
  input  logic [1023:0] ddr3_rd_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [31:0]   pix_data,
  output logic          underrun
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0] LAST_LINE = 10'(FRAME_BLOCKS - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_d;
  logic            discard, discard_d;
  logic            req, capture, accept, pop;
  logic [1023:0]   line_buf [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [4:0]      word_idx;
  logic [9:0]      next_line;

  assign pix_valid = (count != '0);
  assign pix_data  = pix_valid ? line_buf[rd_ptr][{word_idx, 5'b0} +: 32] : '0;
  assign accept    = pix_valid & pix_ready;
  assign pop       = accept & (word_idx == 5'd31);

  always_ff @(posedge ddr3_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_d;
      discard <= discard_d;
    end
  end

  // A frame_start while a line is outstanding marks it for discard; one coinciding
  // with the returning line drops it directly without touching the flag.
  always_comb begin
    state_d   = state;
    discard_d = discard;
    req       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && !frame_start && (count < CW'(FIFO_DEPTH))) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ddr3_data_valid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          capture   = !discard && !frame_start;
        end else if (frame_start) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk) begin
    if (!reset && capture) line_buf[wr_ptr] <= ddr3_rd_data;
  end

  always_ff @(posedge ddr3_clk) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_idx  <= '0;
      next_line <= '0;
      underrun  <= 1'b0;
    end else begin
      rd_valid <= req;
      if (req) rd_addr <= next_line;
      if (frame_start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        word_idx  <= '0;
        next_line <= '0;
        underrun  <= 1'b0;
      end else begin
        if (pix_ready && !pix_valid) underrun <= 1'b1;
        if (accept) word_idx <= word_idx + 5'd1;
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (capture) begin
          wr_ptr    <= wr_ptr + PW'(1);
          next_line <= (next_line == LAST_LINE) ? '0 : next_line + 10'd1;
        end
        unique case ({capture, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
